ncl_sum_receiver: RTL

Clocked receiver for the dual-rail sum bus of the 32-digit NCL counter. It consumes DATA/NULL wavefronts from the counter's sum digits and drives their completion/acknowledge. It converts each complete DATA wavefront to a single-rail binary value and checks that successive values increment by one. It replaces the per-digit auto-consume gates when the counter is observed from a synchronous test or monitor domain.

---
 rtl/ncl_pkg.sv | 23 ++
 rtl/ncl_dr_sync.sv | 40 ++++
 rtl/ncl_sum_receiver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ncl_pkg.sv
// Shared definitions for the NCL counter's dual-rail sum bus:
// code points, receiver state encoding and rail-1 extraction.
package ncl_pkg;

   typedef logic [1:0] dr_t;

   localparam dr_t DR_NULL = 2'b00;
   localparam dr_t DR_0    = 2'b01;
   localparam dr_t DR_1    = 2'b10;
   localparam dr_t DR_ILL  = 2'b11;

   typedef enum logic [1:0] {
      FLUSH     = 2'd0,
      WAIT_DATA = 2'd1,
      WAIT_NULL = 2'd2
   } rx_state_t;

   // Rail 1 is the binary value of a DATA digit; NULL also reads as 0.
   function automatic logic dr_to_bin(input dr_t code);
      return code[1];
   endfunction

endpackage

// File: rtl/ncl_dr_sync.sv
// Multi-stage synchronizer for asynchronous dual-rail inputs, plus a
// fill flag that goes high once every stage holds a sample taken after init.
module ncl_dr_sync
   import ncl_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             init,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   logic [WIDTH-1:0] stage [DEPTH];
   logic [DEPTH-1:0] fill;

   // The fill chain travels alongside the data so the receiver never trusts
   // the reset zeros as a real NULL wavefront.
   always_ff @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
         fill <= '0;
      end else begin
         stage[0] <= d;
         fill[0]  <= 1'b1;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
            fill[i]  <= fill[i-1];
         end
      end
   end

   assign q     = stage[DEPTH-1];
   assign valid = fill[DEPTH-1];

endmodule

// File: rtl/ncl_sum_receiver.sv
// Synchronous receiver for the NCL counter sum bus: acknowledges DATA/NULL
// wavefronts, captures each DATA value and checks the +1 sequence.
module ncl_sum_receiver
   import ncl_pkg::*;
#(
   parameter int DIGITS      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int CHECK_SEQ   = 1,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                init,
   input  logic [2*DIGITS-1:0] sum_dr,
   output logic [DIGITS-1:0]   ack,
   output logic [DIGITS-1:0]   value,
   output logic                value_valid,
   output logic                seq_err,
   output logic                code_err,
   output logic [CNT_W-1:0]    wavefront_count
);

   logic [2*DIGITS-1:0] sync_q;
   logic                sync_valid;

   rx_state_t           state;
   rx_state_t           state_next;

   logic                all_data;
   logic                all_null;
   logic                any_ill;
   logic [DIGITS-1:0]   rail1;
   logic                ack_bit;
   logic                capture;
   logic                baseline;
   logic [DIGITS-1:0]   value_inc;

   ncl_dr_sync #(
      .WIDTH (2*DIGITS),
      .DEPTH (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .init  (init),
      .d     (sum_dr),
      .q     (sync_q),
      .valid (sync_valid)
   );

   // An illegal 11 digit makes the wavefront neither complete DATA nor complete NULL.
   always_comb begin
      all_data = 1'b1;
      all_null = 1'b1;
      any_ill  = 1'b0;
      rail1    = '0;
      for (int k = 0; k < DIGITS; k++) begin
         rail1[k] = dr_to_bin(sync_q[2*k +: 2]);
         if (sync_q[2*k +: 2] == DR_ILL) begin
            any_ill  = 1'b1;
            all_data = 1'b0;
            all_null = 1'b0;
         end else if (sync_q[2*k +: 2] == DR_NULL) begin
            all_data = 1'b0;
         end else begin
            all_null = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state <= FLUSH;
      end else begin
         state <= state_next;
      end
   end

   // FLUSH only leaves on a NULL that was sampled after init, so any DATA
   // wavefront in flight at reset is thrown away.
   always_comb begin
      state_next = state;
      case (state)
         FLUSH:     if (sync_valid && all_null) state_next = WAIT_DATA;
         WAIT_DATA: if (all_data)               state_next = WAIT_NULL;
         WAIT_NULL: if (all_null)               state_next = WAIT_DATA;
         default:                               state_next = FLUSH;
      endcase
   end

   always_comb begin
      ack_bit = (state == WAIT_NULL);
      capture = (state == WAIT_DATA) && all_data;
   end

   assign ack       = {DIGITS{ack_bit}};
   assign value_inc = value + {{(DIGITS-1){1'b0}}, 1'b1};

   // The first capture after init only sets the baseline for the +1 check.
   always_ff @(posedge clk) begin
      if (init) begin
         value           <= '0;
         value_valid     <= 1'b0;
         seq_err         <= 1'b0;
         code_err        <= 1'b0;
         wavefront_count <= '0;
         baseline        <= 1'b0;
      end else begin
         value_valid <= capture;
         if (any_ill) begin
            code_err <= 1'b1;
         end
         if (capture) begin
            value           <= rail1;
            wavefront_count <= wavefront_count + {{(CNT_W-1){1'b0}}, 1'b1};
            baseline        <= 1'b1;
            if ((CHECK_SEQ != 0) && baseline && (rail1 != value_inc)) begin
               seq_err <= 1'b1;
            end
         end
      end
   end

endmodule
